// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int FRAME_BITS           = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 6;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops preset to RST_VAL.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling, one-byte holding register with valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  input  logic                  sin,
  input  logic                  rx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy_rx
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(FRAME_BITS - 1);

  logic s_in;

  rx_state_t             state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [2:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  s_prev_q, s_prev_d;
  logic                  load_q, load_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  overrun_q, overrun_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_sin (
    .clk (fpga_clk),
    .rst (rst),
    .d   (sin),
    .q   (s_in)
  );

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    s_prev_d  = s_in;
    load_d    = 1'b0;
    ferr_d    = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (valid_q && rx_ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // A pending byte either lands (slot free or freed this cycle) or is dropped as overrun.
    if (load_q) begin
      if (valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        // Only a falling edge starts a frame, so a held-low line cannot retrigger.
        if (!s_in && s_prev_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          if (!s_in) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (MSB_FIRST) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], s_in};
          end else begin
            shreg_d = {s_in, shreg_q[FRAME_BITS-1:1]};
          end
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = IDLE;
          if (s_in) begin
            load_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge fpga_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      s_prev_q  <= 1'b1;
      load_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      s_prev_q  <= s_prev_d;
      load_q    <= load_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
  assign busy_rx   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level event schedule model plus directed literal checks.
module tb_uart_rx;

  localparam int CPB = 6;

  logic       fpga_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       sin      = 1'b1;
  logic       rx_ready = 1'b0;
  logic       sin2     = 1'b1;
  logic       rx_ready2 = 1'b0;

  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, frame_err, overrun, busy_rx;
  logic       rx_valid2, frame_err2, overrun2, busy_rx2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rand_ready_en = 1'b0;

  // Expected events keyed by clock-edge index, derived from frame start times.
  logic [7:0] load_at [int];
  bit         ferr_at [int];
  bit         busy_at [int];

  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_busy  = 1'b0;
  bit         m_old_valid;

  always #5 fpga_clk = ~fpga_clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut (
    .fpga_clk  (fpga_clk),
    .rst       (rst),
    .sin       (sin),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy_rx   (busy_rx)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_lsb (
    .fpga_clk  (fpga_clk),
    .rst       (rst),
    .sin       (sin2),
    .rx_ready  (rx_ready2),
    .rx_data   (rx_data2),
    .rx_valid  (rx_valid2),
    .frame_err (frame_err2),
    .overrun   (overrun2),
    .busy_rx   (busy_rx2)
  );

  // Holding-register model: one byte slot, accept frees it, a byte arriving into a full slot is dropped.
  always @(posedge fpga_clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
    end else begin
      m_old_valid = m_valid;
      if (m_old_valid && rx_ready) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (load_at.exists(cyc)) begin
        if (m_old_valid && !rx_ready) begin
          m_ovr = 1'b1;
        end else begin
          m_data  = load_at[cyc];
          m_valid = 1'b1;
        end
      end
      m_ferr = ferr_at.exists(cyc);
      m_busy = busy_at.exists(cyc);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge fpga_clk);
      #1;
    end
  endtask

  // Drives a 10-bit frame, bits[0] first, one bit period each; call 1 unit after an edge.
  task automatic driveBits(input logic [9:0] bits, input bit to_dut2);
    for (int i = 0; i < 10; i++) begin
      if (to_dut2) sin2 = bits[i];
      else         sin  = bits[i];
      waitCycles(CPB);
    end
  endtask

  // Frame sent MSB first on the main DUT. Start seen 3 edges after the line falls (2 sync + detect),
  // stop bit sampled half a bit plus 9 bit periods later, byte lands one edge after that.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_ok);
    int e;
    int s;
    logic [9:0] f;
    e = cyc;
    s = e + 3 + CPB / 2 + 9 * CPB;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[7-i];
    f[9] = stop_ok;
    for (int k = e + 3; k < s; k++) busy_at[k] = 1'b1;
    if (stop_ok) load_at[s+1] = b;
    else         ferr_at[s]   = 1'b1;
    driveBits(f, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] f;
    bit         ok;
    bit         found;
    int         e;
    int         gap;

    fork
      begin : monitor
        forever begin
          @(negedge fpga_clk);
          if (rst) begin
            checkOutput("rst_rx_data", rx_data, 8'h00);
            checkOutput("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
            checkOutput("rst_frame_err", {7'b0, frame_err}, 8'h00);
            checkOutput("rst_overrun", {7'b0, overrun}, 8'h00);
            checkOutput("rst_busy_rx", {7'b0, busy_rx}, 8'h00);
          end else begin
            checkOutput("rx_data", rx_data, m_data);
            checkOutput("rx_valid", {7'b0, rx_valid}, {7'b0, m_valid});
            checkOutput("frame_err", {7'b0, frame_err}, {7'b0, m_ferr});
            checkOutput("overrun", {7'b0, overrun}, {7'b0, m_ovr});
            checkOutput("busy_rx", {7'b0, busy_rx}, {7'b0, m_busy});
          end
        end
      end
      begin : ready_driver
        forever begin
          @(posedge fpga_clk);
          #1;
          if (rand_ready_en) rx_ready = ($urandom_range(0, 3) == 0);
        end
      end
      begin : stimulus
        waitCycles(3);
        rst = 1'b0;
        waitCycles(4);

        // 0xA5 held, then accepted.
        applyStimulus(8'hA5, 1'b1);
        @(negedge fpga_clk);
        checkOutput("a5_valid_not_yet", {7'b0, rx_valid}, 8'h00);
        @(negedge fpga_clk);
        checkOutput("a5_valid", {7'b0, rx_valid}, 8'h01);
        checkOutput("a5_data", rx_data, 8'hA5);
        checkOutput("a5_ferr", {7'b0, frame_err}, 8'h00);
        rx_ready = 1'b1;
        @(negedge fpga_clk);
        checkOutput("a5_accepted", {7'b0, rx_valid}, 8'h00);
        rx_ready = 1'b0;
        waitCycles(6);

        // 0x3C with a bad stop bit.
        applyStimulus(8'h3C, 1'b0);
        @(negedge fpga_clk);
        checkOutput("3c_ferr_pulse", {7'b0, frame_err}, 8'h01);
        checkOutput("3c_valid", {7'b0, rx_valid}, 8'h00);
        checkOutput("3c_data_kept", rx_data, 8'hA5);
        @(negedge fpga_clk);
        checkOutput("3c_ferr_cleared", {7'b0, frame_err}, 8'h00);
        sin = 1'b1;
        waitCycles(12);

        // Two-clock glitch is rejected at mid start bit.
        e = cyc;
        for (int k = e + 3; k < e + 3 + CPB / 2; k++) busy_at[k] = 1'b1;
        sin = 1'b0;
        waitCycles(2);
        sin = 1'b1;
        waitCycles(10);
        @(negedge fpga_clk);
        checkOutput("glitch_busy", {7'b0, busy_rx}, 8'h00);
        checkOutput("glitch_valid", {7'b0, rx_valid}, 8'h00);
        waitCycles(1);

        // Back-to-back 0x11, 0x22 with no consumer.
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        @(negedge fpga_clk);
        @(negedge fpga_clk);
        checkOutput("ovr_data", rx_data, 8'h11);
        checkOutput("ovr_flag", {7'b0, overrun}, 8'h01);
        rx_ready = 1'b1;
        @(negedge fpga_clk);
        checkOutput("ovr_cleared", {7'b0, overrun}, 8'h00);
        checkOutput("ovr_valid_cleared", {7'b0, rx_valid}, 8'h00);
        rx_ready = 1'b0;
        waitCycles(4);

        // Break: line held low well past the frame.
        applyStimulus(8'h00, 1'b0);
        @(negedge fpga_clk);
        checkOutput("break_ferr", {7'b0, frame_err}, 8'h01);
        waitCycles(30);
        @(negedge fpga_clk);
        checkOutput("break_idle", {7'b0, busy_rx}, 8'h00);
        sin = 1'b1;
        waitCycles(10);
        applyStimulus(8'h5A, 1'b1);
        waitCycles(3);

        // Reset during bit 4 of 0xFF, then 0x0F.
        e = cyc;
        for (int k = e + 3; k < e + 3 + CPB / 2 + 9 * CPB; k++) busy_at[k] = 1'b1;
        sin = 1'b0;
        waitCycles(CPB);
        sin = 1'b1;
        waitCycles(4 * CPB + 3);
        rst = 1'b1;
        load_at.delete();
        ferr_at.delete();
        busy_at.delete();
        waitCycles(3);
        rst = 1'b0;
        waitCycles(60);
        applyStimulus(8'h0F, 1'b1);
        waitCycles(1);
        @(negedge fpga_clk);
        checkOutput("post_rst_data", rx_data, 8'h0F);
        checkOutput("post_rst_valid", {7'b0, rx_valid}, 8'h01);
        rx_ready = 1'b1;
        @(negedge fpga_clk);
        rx_ready = 1'b0;
        waitCycles(1);

        // 0xC3 MSB first on the main DUT, LSB first on the second.
        applyStimulus(8'hC3, 1'b1);
        @(negedge fpga_clk);
        @(negedge fpga_clk);
        checkOutput("msb_c3_data", rx_data, 8'hC3);
        rx_ready = 1'b1;
        @(negedge fpga_clk);
        rx_ready = 1'b0;
        waitCycles(1);
        b = 8'hC3;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        f[9] = 1'b1;
        driveBits(f, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
          @(negedge fpga_clk);
          if (rx_valid2) found = 1'b1;
        end
        checkOutput("lsb_c3_valid", {7'b0, found}, 8'h01);
        checkOutput("lsb_c3_data", rx_data2, 8'hC3);
        checkOutput("lsb_ferr", {7'b0, frame_err2}, 8'h00);
        checkOutput("lsb_overrun", {7'b0, overrun2}, 8'h00);
        checkOutput("lsb_busy", {7'b0, busy_rx2}, 8'h00);
        waitCycles(1);

        // Random frames, random consumer.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
          b  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          applyStimulus(b, ok);
          gap = ok ? int'($urandom_range(0, 12)) : 3 + int'($urandom_range(0, 12));
          sin = 1'b1;
          waitCycles(gap);
        end
        rand_ready_en = 1'b0;
        rx_ready = 1'b1;
        waitCycles(80);
      end
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
